// File: rtl/key_debounce_multi_if.sv
// Key pins in, debounced level/pulse/flag vectors out; one bit per key channel.
interface key_debounce_multi_if #(
    parameter int IO_NUM = 1
);
    logic [IO_NUM-1:0] I_key;
    logic [IO_NUM-1:0] O_key_level;
    logic [IO_NUM-1:0] O_press_pulse;
    logic [IO_NUM-1:0] O_release_pulse;
    logic [IO_NUM-1:0] O_long_pulse;
    logic [IO_NUM-1:0] O_key_flag;

    modport master (
        output I_key,
        input  O_key_level, O_press_pulse, O_release_pulse, O_long_pulse, O_key_flag
    );

    modport slave (
        input  I_key,
        output O_key_level, O_press_pulse, O_release_pulse, O_long_pulse, O_key_flag
    );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button debouncer: per-key synchroniser + 4-state FSM producing
// debounced level, press/release/long-press pulses and a press toggle flag.
module key_debounce_lane #(
    parameter int DB_CNT     = 20,
    parameter int LONG_CNT   = 100,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic flag_o
);
    localparam int CW  = (DB_CNT   > 1) ? $clog2(DB_CNT)   : 1;
    localparam int LCW = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
    localparam logic [CW-1:0]  DB_LAST   = CW'(DB_CNT - 1);
    localparam logic [LCW-1:0] LONG_LAST = LCW'(LONG_CNT - 1);
    localparam logic           IDLE_PIN  = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LCW-1:0] long_cnt_q, long_cnt_d;
    logic           long_done_q, long_done_d;
    logic           sync1_q, sync2_q;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           long_q, long_d;
    logic           flag_q, flag_d;
    logic           act;
    logic           hold_tick;

    assign act = sync2_q ^ IDLE_PIN;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        flag_d      = flag_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        hold_tick   = 1'b0;
        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!act) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    flag_d      = ~flag_q;
                    long_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!act) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end else begin
                    hold_tick = 1'b1;
                end
            end
            RELEASE_DB: begin
                // The edge that returns to HELD already sees the key active, so it
                // counts as held time: a glitch of N cycles delays long press by N.
                if (act) begin
                    state_d   = HELD;
                    hold_tick = 1'b1;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (hold_tick && !long_done_q) begin
            if (long_cnt_q == LONG_LAST) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end else begin
                long_cnt_d = long_cnt_q + LCW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            sync1_q     <= IDLE_PIN;
            sync2_q     <= IDLE_PIN;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            sync1_q     <= key_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            flag_q      <= flag_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign flag_o    = flag_q;
endmodule

module key_debounce_multi #(
    parameter int CLK_FREQ    = 27_000_000,
    parameter int IO_NUM      = 1,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 500,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    key_debounce_multi_if.slave  kif
);
    localparam int CYC_PER_MS = CLK_FREQ / 1000;
    localparam int DB_CNT     = CYC_PER_MS * DEBOUNCE_MS;
    localparam int LONG_CNT   = CYC_PER_MS * LONG_MS;

    if (LONG_MS <= DEBOUNCE_MS || IO_NUM < 1 || CLK_FREQ < 1000) begin : g_cfg_err
        $error("key_debounce_multi: bad configuration (need LONG_MS > DEBOUNCE_MS, IO_NUM >= 1, CLK_FREQ >= 1000)");
    end

    for (genvar g = 0; g < IO_NUM; g++) begin : g_lane
        key_debounce_lane #(
            .DB_CNT     (DB_CNT),
            .LONG_CNT   (LONG_CNT),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_lane (
            .clk_i     (I_clk),
            .rst_ni    (I_rst_n),
            .key_i     (kif.I_key[g]),
            .level_o   (kif.O_key_level[g]),
            .press_o   (kif.O_press_pulse[g]),
            .release_o (kif.O_release_pulse[g]),
            .long_o    (kif.O_long_pulse[g]),
            .flag_o    (kif.O_key_flag[g])
        );
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench: expected pulse events (cycle, lane, kind) are queued when keys are
// driven and matched against every pulse the DUT emits.
module tb_key_debounce_multi;
    localparam int N = 4;
    localparam int K_PRESS = 1, K_LONG = 2, K_REL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    longint sb_q[$];

    key_debounce_multi_if #(.IO_NUM(N)) kif();

    key_debounce_multi #(
        .CLK_FREQ(10_000), .IO_NUM(N), .DEBOUNCE_MS(2), .LONG_MS(10), .ACTIVE_LOW(1)
    ) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .kif     (kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%0d exp=%0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint ev(input int c, input int lane, input int kind);
        return longint'(c) * 16 + longint'(lane * 4 + kind);
    endfunction

    task automatic expect_ev(input int c, input int lane, input int kind);
        sb_q.push_back(ev(c, lane, kind));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses observed in the same cycle are matched in lane order, then press/long/release.
    always @(negedge clk) begin
        for (int l = 0; l < N; l++) begin
            for (int k = K_PRESS; k <= K_REL; k++) begin
                logic p;
                p = (k == K_PRESS) ? kif.O_press_pulse[l] :
                    (k == K_LONG)  ? kif.O_long_pulse[l]  : kif.O_release_pulse[l];
                if (p === 1'b1) begin
                    if (sb_q.size() == 0) chk("sb_unexpected", ev(cyc, l, k), 0);
                    else chk("sb_pulse", ev(cyc, l, k), sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int p;
        kif.I_key = '1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_level", kif.O_key_level, 0);
        chk("rst_flag",  kif.O_key_flag, 0);
        chk("rst_press", kif.O_press_pulse, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // clean press on key0, held 150 cycles past the press pulse, then released
        p = cyc + 23;
        kif.I_key[0] = 1'b0;
        expect_ev(p, 0, K_PRESS);
        expect_ev(p + 100, 0, K_LONG);
        tick(25);
        chk("t1_level", kif.O_key_level[0], 1);
        chk("t1_flag",  kif.O_key_flag[0], 1);
        tick(148);
        kif.I_key[0] = 1'b1;
        expect_ev(cyc + 23, 0, K_REL);
        tick(30);
        chk("t3_level", kif.O_key_level[0], 0);
        chk("t3_flag",  kif.O_key_flag[0], 1);

        // bounce on key1: 15 low, 3 high, 30 low
        kif.I_key[1] = 1'b0;
        tick(15);
        kif.I_key[1] = 1'b1;
        tick(3);
        kif.I_key[1] = 1'b0;
        expect_ev(cyc + 23, 1, K_PRESS);
        tick(30);
        kif.I_key[1] = 1'b1;
        expect_ev(cyc + 23, 1, K_REL);
        tick(30);
        chk("t2_flag",  kif.O_key_flag[1], 1);
        chk("t2_level", kif.O_key_level[1], 0);

        // release glitch on key2 during HELD delays the long pulse by its length
        p = cyc + 23;
        kif.I_key[2] = 1'b0;
        expect_ev(p, 2, K_PRESS);
        expect_ev(p + 105, 2, K_LONG);
        tick(40);
        kif.I_key[2] = 1'b1;
        tick(5);
        chk("t4_glitch_level", kif.O_key_level[2], 1);
        kif.I_key[2] = 1'b0;
        tick(100);
        chk("t4_level", kif.O_key_level[2], 1);
        kif.I_key[2] = 1'b1;
        expect_ev(cyc + 23, 2, K_REL);
        tick(30);

        // keys 0 and 3 pressed together
        p = cyc + 23;
        kif.I_key[0] = 1'b0;
        kif.I_key[3] = 1'b0;
        expect_ev(p, 0, K_PRESS);
        expect_ev(p, 3, K_PRESS);
        tick(25);
        chk("t5_level", kif.O_key_level, 4'b1001);
        chk("t5_flag",  kif.O_key_flag, 4'b1110);
        tick(20);

        // asynchronous reset mid-HELD with keys still held
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_level", kif.O_key_level, 0);
        chk("t6_rst_flag",  kif.O_key_flag, 0);
        tick(2);
        rst_n = 1'b1;
        expect_ev(cyc + 23, 0, K_PRESS);
        expect_ev(cyc + 23, 3, K_PRESS);
        tick(25);
        chk("t6_level", kif.O_key_level, 4'b1001);
        chk("t6_flag",  kif.O_key_flag, 4'b1001);
        kif.I_key[0] = 1'b1;
        kif.I_key[3] = 1'b1;
        expect_ev(cyc + 23, 0, K_REL);
        expect_ev(cyc + 23, 3, K_REL);
        tick(30);
        chk("t6_end_level", kif.O_key_level, 0);

        chk("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
